// File: rtl/pdec_occ_pkg.sv
// Shared occupancy-tracking parameters, also used by the ROB allocator.
// Latency: n/a (constants and helper only).
// Backpressure: n/a.
package pdec_occ_pkg;

  // Default number of tracked slots.
  localparam int OCC_WIDTH_DEF = 16;

  // Slot index width for a tracker of n slots.
  function automatic int occ_idxw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pdec_occ_penc.sv
// Priority encoder: index of the highest-numbered set bit of req.
// Latency: combinational.
// Backpressure: none; idx is 0 and found is low when req is all zero.
module penc #(
  parameter int W  = 16,
  parameter int OW = 4
) (
  input  logic [W-1:0]  req,
  output logic [OW-1:0] idx,
  output logic          found
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (req[i]) begin
        idx   = OW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdec_occ.sv
// Slot occupancy tracker: set/clear slots by index, keeps bitmap, count and free-slot search.
// Latency: 1 cycle from request to vec/cnt/flags/error pulses; free_idx is combinational from vec.
// Backpressure: set_rdy = !full from registered state only; clears are always accepted.
module pdec_occ
  import pdec_occ_pkg::*;
#(
  parameter  int WIDTH = OCC_WIDTH_DEF,
  localparam int IDXW  = occ_idxw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_vld,
  input  logic [IDXW-1:0]  set_idx,
  output logic             set_rdy,
  input  logic             clr_vld,
  input  logic [IDXW-1:0]  clr_idx,
  output logic [WIDTH-1:0] vec,
  output logic [IDXW:0]    cnt,
  output logic             full,
  output logic             empty,
  output logic [IDXW-1:0]  free_idx,
  output logic             free_found,
  output logic             dbl_set_err,
  output logic             bad_clr_err,
  output logic             range_err
);

  localparam logic [IDXW:0] FULL_CNT = (IDXW + 1)'(WIDTH);

  logic             set_in_rng;
  logic             clr_in_rng;
  logic             set_ok;
  logic             clr_ok;
  logic [WIDTH-1:0] set_dec;
  logic [WIDTH-1:0] clr_dec;
  logic             set_hit;
  logic             clr_hit;
  logic             same_slot;
  logic             eff_set;
  logic             eff_clr;
  logic             dbl_nxt;
  logic             bad_nxt;
  logic             rng_nxt;
  logic [WIDTH-1:0] vec_nxt;
  logic [IDXW:0]    cnt_nxt;

  // A set is only taken while not full, judged on last cycle's registered count.
  assign set_rdy = !full;

  // Index checks; out-of-range indices can only occur for non power-of-2 WIDTH.
  assign set_in_rng = 32'(set_idx) < WIDTH;
  assign clr_in_rng = 32'(clr_idx) < WIDTH;
  assign set_ok     = set_vld && set_rdy && set_in_rng;
  assign clr_ok     = clr_vld && clr_in_rng;

  // Inline index-to-one-hot decode; an out-of-range index decodes to all zero.
  always_comb begin
    set_dec = '0;
    clr_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      set_dec[i] = (32'(set_idx) == i);
      clr_dec[i] = (32'(clr_idx) == i);
    end
  end

  // Classify this cycle's requests against current occupancy.
  always_comb begin
    set_hit   = |(vec & set_dec);
    clr_hit   = |(vec & clr_dec);
    same_slot = set_ok && clr_ok && (set_idx == clr_idx);
    // Set+clear on one occupied slot cancels out: bit stays, count stays.
    eff_set   = set_ok && !set_hit;
    eff_clr   = clr_ok && clr_hit && !same_slot;
    dbl_nxt   = set_ok && set_hit && !same_slot;
    bad_nxt   = clr_ok && !clr_hit;
    rng_nxt   = (set_vld && !set_in_rng) || (clr_vld && !clr_in_rng);
    vec_nxt   = (vec & ~(eff_clr ? clr_dec : '0)) | (eff_set ? set_dec : '0);
    cnt_nxt   = cnt + (IDXW + 1)'(eff_set) - (IDXW + 1)'(eff_clr);
  end

  // Occupancy state, flags and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec         <= '0;
      cnt         <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      dbl_set_err <= 1'b0;
      bad_clr_err <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      vec         <= vec_nxt;
      cnt         <= cnt_nxt;
      full        <= (cnt_nxt == FULL_CNT);
      empty       <= (cnt_nxt == '0);
      dbl_set_err <= dbl_nxt;
      bad_clr_err <= bad_nxt;
      range_err   <= rng_nxt;
    end
  end

  // Highest-numbered free slot.
  penc #(
    .W  (WIDTH),
    .OW (IDXW)
  ) u_penc (
    .req   (~vec),
    .idx   (free_idx),
    .found (free_found)
  );

endmodule

// File: tb/tb_pdec_occ.sv
// Bench for pdec_occ: a 16-slot and a 12-slot instance against a slot-array model.
// Latency: outputs checked 1 ns after each rising edge.
// Backpressure: model drops sets while its own count equals the width.
module tb_pdec_occ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 16-slot instance
  logic        a_set_vld, a_clr_vld, a_set_rdy;
  logic [3:0]  a_set_idx, a_clr_idx, a_free_idx;
  logic [15:0] a_vec;
  logic [4:0]  a_cnt;
  logic        a_full, a_empty, a_free_found, a_dbl, a_bad, a_rng;

  // 12-slot instance
  logic        b_set_vld, b_clr_vld, b_set_rdy;
  logic [3:0]  b_set_idx, b_clr_idx, b_free_idx;
  logic [11:0] b_vec;
  logic [4:0]  b_cnt;
  logic        b_full, b_empty, b_free_found, b_dbl, b_bad, b_rng;

  pdec_occ #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .set_vld(a_set_vld), .set_idx(a_set_idx), .set_rdy(a_set_rdy),
    .clr_vld(a_clr_vld), .clr_idx(a_clr_idx),
    .vec(a_vec), .cnt(a_cnt), .full(a_full), .empty(a_empty),
    .free_idx(a_free_idx), .free_found(a_free_found),
    .dbl_set_err(a_dbl), .bad_clr_err(a_bad), .range_err(a_rng)
  );

  pdec_occ #(.WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .set_vld(b_set_vld), .set_idx(b_set_idx), .set_rdy(b_set_rdy),
    .clr_vld(b_clr_vld), .clr_idx(b_clr_idx),
    .vec(b_vec), .cnt(b_cnt), .full(b_full), .empty(b_empty),
    .free_idx(b_free_idx), .free_found(b_free_found),
    .dbl_set_err(b_dbl), .bad_clr_err(b_bad), .range_err(b_rng)
  );

  // Model: one occupancy flag per slot for each instance.
  bit occ [2][64];
  int wd [2] = '{16, 12};

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) occ[d][i] = 1'b0;
  endtask

  function automatic int model_cnt(input int d);
    int n = 0;
    for (int i = 0; i < wd[d]; i++) n += int'(occ[d][i]);
    return n;
  endfunction

  // Compare every output of instance d against the model.
  task automatic check_all(input int d, input bit e_dbl, input bit e_bad, input bit e_rng);
    logic [63:0] ev;
    int n, fi;
    bit ff;
    ev = '0;
    fi = 0;
    ff = 1'b0;
    for (int i = 0; i < wd[d]; i++) begin
      ev[i] = occ[d][i];
      if (!occ[d][i]) begin
        fi = i;
        ff = 1'b1;
      end
    end
    n = model_cnt(d);
    if (d == 0) begin
      chk_eq("a_vec", 64'(a_vec), ev);
      chk_eq("a_cnt", 64'(a_cnt), 64'(n));
      chk_eq("a_full", 64'(a_full), 64'(n == 16));
      chk_eq("a_empty", 64'(a_empty), 64'(n == 0));
      chk_eq("a_set_rdy", 64'(a_set_rdy), 64'(n != 16));
      chk_eq("a_free_found", 64'(a_free_found), 64'(ff));
      if (ff) chk_eq("a_free_idx", 64'(a_free_idx), 64'(fi));
      chk_eq("a_dbl", 64'(a_dbl), 64'(e_dbl));
      chk_eq("a_bad", 64'(a_bad), 64'(e_bad));
      chk_eq("a_rng", 64'(a_rng), 64'(e_rng));
    end else begin
      chk_eq("b_vec", 64'(b_vec), ev);
      chk_eq("b_cnt", 64'(b_cnt), 64'(n));
      chk_eq("b_full", 64'(b_full), 64'(n == 12));
      chk_eq("b_empty", 64'(b_empty), 64'(n == 0));
      chk_eq("b_set_rdy", 64'(b_set_rdy), 64'(n != 12));
      chk_eq("b_free_found", 64'(b_free_found), 64'(ff));
      if (ff) chk_eq("b_free_idx", 64'(b_free_idx), 64'(fi));
      chk_eq("b_dbl", 64'(b_dbl), 64'(e_dbl));
      chk_eq("b_bad", 64'(b_bad), 64'(e_bad));
      chk_eq("b_rng", 64'(b_rng), 64'(e_rng));
    end
  endtask

  // One request cycle on instance d; the model applies clear then set.
  task automatic step(input int d, input bit sv, input int si, input bit cv, input int ci);
    bit full_pre, set_take, clr_take, e_dbl, e_bad, e_rng;
    logic [3:0] si4, ci4;
    si4 = si[3:0];
    ci4 = ci[3:0];
    full_pre = (model_cnt(d) == wd[d]);
    set_take = sv && !full_pre && (si < wd[d]);
    clr_take = cv && (ci < wd[d]);
    e_rng = (sv && si >= wd[d]) || (cv && ci >= wd[d]);
    e_dbl = set_take && occ[d][si] && !(clr_take && ci == si);
    e_bad = clr_take && !occ[d][ci];
    if (clr_take) occ[d][ci] = 1'b0;
    if (set_take) occ[d][si] = 1'b1;
    a_set_vld = (d == 0) && sv; a_set_idx = si4;
    a_clr_vld = (d == 0) && cv; a_clr_idx = ci4;
    b_set_vld = (d == 1) && sv; b_set_idx = si4;
    b_clr_vld = (d == 1) && cv; b_clr_idx = ci4;
    @(posedge clk);
    #1;
    a_set_vld = 1'b0; a_clr_vld = 1'b0;
    b_set_vld = 1'b0; b_clr_vld = 1'b0;
    check_all(d, e_dbl, e_bad, e_rng);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #2;
    check_all(0, 1'b0, 1'b0, 1'b0);
    check_all(1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    a_set_vld = 1'b0; a_clr_vld = 1'b0; a_set_idx = '0; a_clr_idx = '0;
    b_set_vld = 1'b0; b_clr_vld = 1'b0; b_set_idx = '0; b_clr_idx = '0;
    model_clear();

    // Values held during reset
    #12;
    chk_eq("rst_set_rdy", 64'(a_set_rdy), 64'd1);
    chk_eq("rst_free_idx16", 64'(a_free_idx), 64'd15);
    chk_eq("rst_free_idx12", 64'(b_free_idx), 64'd11);
    chk_eq("rst_empty", 64'(a_empty), 64'd1);
    check_all(0, 1'b0, 1'b0, 1'b0);
    check_all(1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0..15
    for (int i = 0; i < 16; i++) step(0, 1'b1, i, 1'b0, 0);
    chk_eq("fill_vec", 64'(a_vec), 64'hFFFF);
    chk_eq("fill_cnt", 64'(a_cnt), 64'd16);
    chk_eq("fill_rdy", 64'(a_set_rdy), 64'd0);
    chk_eq("fill_ff", 64'(a_free_found), 64'd0);

    // Full boundary: set is refused, clear goes through, set retried next cycle
    step(0, 1'b1, 2, 1'b1, 9);
    chk_eq("fullrel_vec", 64'(a_vec), 64'hFDFF);
    chk_eq("fullrel_cnt", 64'(a_cnt), 64'd15);
    step(0, 1'b1, 9, 1'b0, 0);
    chk_eq("fullrel_set9", 64'(a_vec), 64'hFFFF);

    // Free-slot search
    step(0, 1'b0, 0, 1'b1, 15);
    chk_eq("search_7fff", 64'(a_free_idx), 64'd15);
    step(0, 1'b1, 15, 1'b1, 0);
    chk_eq("search_fffe_vec", 64'(a_vec), 64'hFFFE);
    chk_eq("search_fffe", 64'(a_free_idx), 64'd0);

    // Async reset mid-operation, away from the clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_eq("async_vec", 64'(a_vec), 64'd0);
    chk_eq("async_cnt", 64'(a_cnt), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // Double set
    step(0, 1'b1, 5, 1'b0, 0);
    step(0, 1'b1, 5, 1'b0, 0);
    chk_eq("dbl_pulse", 64'(a_dbl), 64'd1);
    chk_eq("dbl_vec", 64'(a_vec), 64'h0020);
    chk_eq("dbl_cnt", 64'(a_cnt), 64'd1);
    step(0, 1'b0, 0, 1'b0, 0);

    // Simultaneous same-slot set and clear
    do_reset();
    step(0, 1'b1, 3, 1'b0, 0);
    step(0, 1'b1, 3, 1'b1, 3);
    chk_eq("same_occ_vec", 64'(a_vec), 64'h0008);
    chk_eq("same_occ_bad", 64'(a_bad), 64'd0);
    step(0, 1'b1, 7, 1'b1, 7);
    chk_eq("same_free_vec", 64'(a_vec), 64'h0088);
    chk_eq("same_free_cnt", 64'(a_cnt), 64'd2);
    chk_eq("same_free_bad", 64'(a_bad), 64'd1);
    step(0, 1'b0, 0, 1'b0, 0);

    // Range on the 12-slot instance
    step(1, 1'b1, 4, 1'b0, 0);
    step(1, 1'b1, 13, 1'b0, 0);
    chk_eq("range_pulse", 64'(b_rng), 64'd1);
    chk_eq("range_vec", 64'(b_vec), 64'h010);
    step(1, 1'b0, 0, 1'b1, 14);
    step(1, 1'b0, 0, 1'b0, 0);

    // Random traffic, alternating fill-biased and drain-biased phases
    do_reset();
    for (int n = 0; n < 1600; n++) begin
      int sp;
      sp = ((n / 200) % 2 == 0) ? 8 : 4;
      step(0, $urandom_range(0, 9) < sp, int'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 10 - sp, int'($urandom_range(0, 15)));
    end
    for (int n = 0; n < 1600; n++) begin
      int sp;
      sp = ((n / 200) % 2 == 0) ? 8 : 4;
      step(1, $urandom_range(0, 9) < sp, int'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 10 - sp, int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
